spoc_rate_buffer: RTL
=====================

# spoc_rate_buffer

Parametrised rate-block buffer for the SpoC family: a generalised, handshaked version of the bdi register, padding, truncation and tag-check logic in the SpoC-64 datapath. It assembles PW-bit input words into one RATE-bit block. It applies 10* byte padding and produces the ciphertext or plaintext stream against keystream taken from the permutation state. It hands the padded block and its partial flag to the permutation controller. It serves SpoC-64 (RATE=64) and SpoC-128 (RATE=128) with one RTL.

## Interface
- PW, 32, bus word width in bits; 32 or 64; RATE % PW == 0
- RATE, 64, rate block width in bits; 64 or 128
- TAGW, 64, tag width compared in verify mode; multiple of PW
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- bdi  in  PW  input data word, MSB-first bytes
- bdi_size  in  $clog2(PW/8)+1  valid bytes in word, 0..PW/8, left-aligned
- bdi_last  in  1  last word of the segment
- bdi_valid / bdi_ready  in / out  1  input handshake
- mode  in  2  sampled on the first word of a block: 0 = AD, 1 = encrypt, 2 = decrypt, 3 = tag verify
- ks  in  RATE  keystream (state rate bits), stable while a block is in EMIT
- bdo  out  PW  output word
- bdo_valid / bdo_ready  out / in  1  output handshake
- blk_data  out  RATE  padded block for XOR into the state
- blk_partial  out  1  high when the block was padded
- blk_valid / blk_ready  out / in  1  block handshake to the permutation controller
- msg_auth  out  1  verify result; valid while auth_valid is high
- auth_valid  out  1  one-cycle pulse

## Operation
- FSM states: IDLE, FILL, EMIT, BLK, CMP.
- **IDLE / FILL**
  - bdi_ready = 1.
  - Each accepted word is written at word slot wptr. The byte count n is increased by bdi_size.
  - Bytes beyond bdi_size in the word are zeroed.
- **Leaving FILL**: the block closes when wptr reaches RATE/PW, or on bdi_last.
  - mode 0 goes to BLK.
  - mode 1 or 2 goes to EMIT.
  - mode 3 goes to CMP.
- **EMIT**
  - Outputs ceil(n/(PW/8)) words: bdo = buf_word ^ (mask_word & ks_word).
  - mask keeps only the first n bytes. Output bytes past n are 0.
- **Padding** (applied to the plaintext block)
  - In decrypt mode the padding source is the computed plaintext: buf ^ (mask & ks).
  - n < RATE/8: byte n = 0x80, higher bytes = 0, blk_partial = 1.
  - n == RATE/8: block unchanged, blk_partial = 0.
  - n == 0 with bdi_last (empty final segment): block = 0x80 followed by zeros, blk_partial = 1.
- **BLK**: blk_valid held until blk_ready, then return to IDLE. n and wptr are cleared.
- **CMP**
  - Compares the buffered TAGW bits against ks[RATE-1 -: TAGW].
  - Pulses auth_valid for one cycle with msg_auth = equal, then returns to IDLE.
  - TAGW > RATE is illegal.
- Simultaneous bdi_last with a full block: treated as full; no extra pad block is generated.

## Timing
- Reset values: bdi_ready = 0 during reset and 1 one cycle after release. bdo, bdo_valid, blk_data, blk_partial, blk_valid, msg_auth and auth_valid are all 0. FSM is in IDLE.
- FILL accepts one word per cycle, with no bubble between consecutive words.
- The state after FILL is registered. EMIT, BLK or CMP is entered the cycle after the closing word is accepted.
- EMIT issues one word per cycle while bdo_ready = 1. bdo and bdo_valid are held under backpressure.
- blk_valid is asserted the cycle after the last EMIT word is accepted, or the cycle after FILL closes for AD.
- bdi_ready = 0 in EMIT, BLK and CMP.
- Reset asserted mid-operation: immediate asynchronous return to the reset values; the partial block is discarded.

## Configuration
- SPOC_TAG_VERIFY_EN defined: mode 3 and the CMP state are compiled in.
- SPOC_TAG_VERIFY_EN undefined: CMP and the comparator are removed. mode 3 is treated as AD. msg_auth and auth_valid are tied to 0.

## Structure
- Package spoc_pkg:
  - mode codes MODE_AD, MODE_ENC, MODE_DEC, MODE_VER
  - PAD_BYTE = 8'h80
  - FSM state enum
  - a function returning the byte mask for count n
- Sub-module spoc_pad_mask: combinational. Takes n and the RATE-bit source, and returns the padded block, the truncation mask and blk_partial. It is instantiated once.

## Test plan
- **Full AD block**: RATE=64, PW=32, mode 0, words 0x01234567 then 0x89ABCDEF (last, size 4) -> blk_data = 0x0123456789ABCDEF, blk_partial = 0, no bdo.
- **Partial encrypt**: mode 1, one word 0xAABBCC00, size 3, last; ks = 0x11223344_55667788 -> bdo = 0xBB99FF00, blk_data = 0xAABBCC80_00000000, blk_partial = 1.
- **Decrypt pad from plaintext**: mode 2, same ct 0xBB99FF00, size 3 -> bdo = 0xAABBCC00, blk_data = 0xAABBCC80_00000000.
- **Empty final segment**: bdi_last with size 0 -> blk_data = 0x80000000_00000000, blk_partial = 1.
- **Backpressure and reset**: hold bdo_ready = 0 for 5 cycles in EMIT -> bdo is stable. Then pulse rst low -> all outputs 0, then a fresh block processes correctly.
- **Tag verify** (SPOC_TAG_VERIFY_EN, TAGW=64): matching tag -> auth_valid pulse with msg_auth = 1. Flip one bit -> msg_auth = 0.

Source files
------------

// File: rtl/spoc_pkg.sv
// spoc_pkg: shared definitions for the SpoC rate-block buffer.
// Holds the mode codes, the padding byte, the FSM state type and the
// byte-mask helper used for truncation and size masking.
package spoc_pkg;

  localparam int MAX_RATE = 128;

  localparam logic [1:0] MODE_AD  = 2'd0;
  localparam logic [1:0] MODE_ENC = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;
  localparam logic [1:0] MODE_VER = 2'd3;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_BLK,
    ST_CMP
  } state_t;

  // Mask that keeps the first n bytes (MSB-first) of a rate_bytes-wide
  // vector, right-aligned in a MAX_RATE-bit result.
  function automatic logic [MAX_RATE-1:0] byte_mask(input int n, input int rate_bytes);
    logic [MAX_RATE-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATE/8; i++) begin
      if (i < rate_bytes && i < n) m[(rate_bytes-1-i)*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/spoc_rate_buffer_if.sv
// spoc_rate_buffer_if: input word, output word, block and tag-result
// handshakes of the rate buffer. slave is the buffer side, master the
// side that drives words and consumes blocks.
interface spoc_rate_buffer_if #(
  parameter int PW   = 32,
  parameter int RATE = 64
);
  localparam int SZW = $clog2(PW/8) + 1;

  logic [PW-1:0]   bdi;
  logic [SZW-1:0]  bdi_size;
  logic            bdi_last;
  logic            bdi_valid;
  logic            bdi_ready;
  logic [1:0]      mode;
  logic [RATE-1:0] ks;
  logic [PW-1:0]   bdo;
  logic            bdo_valid;
  logic            bdo_ready;
  logic [RATE-1:0] blk_data;
  logic            blk_partial;
  logic            blk_valid;
  logic            blk_ready;
  logic            msg_auth;
  logic            auth_valid;

  modport slave (
    input  bdi, bdi_size, bdi_last, bdi_valid, mode, ks, bdo_ready, blk_ready,
    output bdi_ready, bdo, bdo_valid, blk_data, blk_partial, blk_valid,
           msg_auth, auth_valid
  );

  modport master (
    output bdi, bdi_size, bdi_last, bdi_valid, mode, ks, bdo_ready, blk_ready,
    input  bdi_ready, bdo, bdo_valid, blk_data, blk_partial, blk_valid,
           msg_auth, auth_valid
  );
endinterface

// File: rtl/spoc_pad_mask.sv
// spoc_pad_mask: combinational 10* byte padding and truncation mask for a
// RATE-bit block holding n valid bytes (MSB-first).
module spoc_pad_mask
  import spoc_pkg::*;
#(
  parameter int RATE = 64,
  localparam int NW  = $clog2(RATE/8) + 1
) (
  input  logic [NW-1:0]   n,
  input  logic [RATE-1:0] src,
  output logic [RATE-1:0] blk,
  output logic [RATE-1:0] mask,
  output logic            partial
);
  localparam int RB = RATE/8;

  logic [MAX_RATE-1:0] mask_full;
  logic [RATE-1:0]     pad_bits;
  logic                unused_mask_lanes;

  assign mask_full = byte_mask(int'(n), RB);
  assign mask      = mask_full[RATE-1:0];
  // Lanes above RATE are always zero; folded so the narrow build stays tidy.
  assign unused_mask_lanes = ^mask_full;
  assign partial   = (int'(n) < RB);

  // Drop the pad byte directly after the last valid byte; none when full.
  always_comb begin
    pad_bits = '0;
    for (int i = 0; i < RB; i++) begin
      if (i == int'(n)) pad_bits[(RB-1-i)*8 +: 8] = PAD_BYTE;
    end
  end

  assign blk = (src & mask) | pad_bits;

endmodule

// File: rtl/spoc_rate_buffer.sv
// spoc_rate_buffer: assembles PW-bit words into a RATE-bit block, emits the
// keystream-xored stream, pads the plaintext block and hands it to the
// permutation controller. Tag verify (mode 3, CMP state) is compiled in
// only when SPOC_TAG_VERIFY_EN is defined; otherwise mode 3 acts as AD.
module spoc_rate_buffer
  import spoc_pkg::*;
#(
  parameter int PW   = 32,
  parameter int RATE = 64,
  parameter int TAGW = 64
) (
  input logic               clk,
  input logic               rst,
  spoc_rate_buffer_if.slave bus
);
  localparam int WORDS = RATE/PW;
  localparam int BPW   = PW/8;
  localparam int NW    = $clog2(RATE/8) + 1;
  localparam int WPW   = $clog2(WORDS) + 1;

  if (TAGW > RATE || (TAGW % PW) != 0) begin : g_bad_tagw
    $error("TAGW must be a multiple of PW and no wider than RATE");
  end

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d, n_acc;
  logic [WPW-1:0]  wptr_q, wptr_d, optr_q, optr_d, emit_words;
  logic [1:0]      mode_q, mode_d, mode_cur;
  logic            rdy_en_q;
  logic [RATE-1:0] blk_buf_q;

  logic [RATE-1:0]     mask, pad_blk, xr;
  logic                partial, accept, emit_last, dec_latch;
  logic [MAX_RATE-1:0] size_mask_full;
  logic [PW-1:0]       bdi_clean;
  logic                unused_size_lanes;

  assign bus.bdi_ready = rdy_en_q && (state_q == ST_IDLE || state_q == ST_FILL);
  assign accept        = bus.bdi_valid && bus.bdi_ready;
  assign mode_cur      = (state_q == ST_IDLE) ? bus.mode : mode_q;
  assign n_acc         = n_q + NW'(bus.bdi_size);

  assign size_mask_full    = byte_mask(int'(bus.bdi_size), BPW);
  assign unused_size_lanes = ^size_mask_full[MAX_RATE-1:PW];
  assign bdi_clean         = bus.bdi & size_mask_full[PW-1:0];

  assign emit_words = WPW'((int'(n_q) + BPW - 1) / BPW);
  assign emit_last  = (optr_q == emit_words - WPW'(1));
  assign xr         = (blk_buf_q ^ (mask & bus.ks)) & mask;
  assign dec_latch  = (state_q == ST_EMIT) && bus.bdo_ready && emit_last && (mode_q == MODE_DEC);

  spoc_pad_mask #(.RATE(RATE)) u_pad (
    .n       (n_q),
    .src     (blk_buf_q),
    .blk     (pad_blk),
    .mask    (mask),
    .partial (partial)
  );

  // Next-state logic: fill, close by mode, emit, hand off, compare.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    optr_d  = optr_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          n_d    = n_acc;
          wptr_d = wptr_q + WPW'(1);
          mode_d = mode_cur;
          state_d = ST_FILL;
          if ((wptr_q + WPW'(1) == WPW'(WORDS)) || bus.bdi_last) begin
            case (mode_cur)
              MODE_ENC, MODE_DEC: state_d = (n_acc == '0) ? ST_BLK : ST_EMIT;
`ifdef SPOC_TAG_VERIFY_EN
              MODE_VER:           state_d = ST_CMP;
`endif
              default:            state_d = ST_BLK;
            endcase
          end
        end
      end
      ST_EMIT: begin
        if (bus.bdo_ready) begin
          if (emit_last) begin
            optr_d  = '0;
            state_d = ST_BLK;
          end else begin
            optr_d = optr_q + WPW'(1);
          end
        end
      end
      ST_BLK: begin
        if (bus.blk_ready) begin
          state_d = ST_IDLE;
          n_d     = '0;
          wptr_d  = '0;
        end
      end
`ifdef SPOC_TAG_VERIFY_EN
      ST_CMP: begin
        state_d = ST_IDLE;
        n_d     = '0;
        wptr_d  = '0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      wptr_q   <= '0;
      optr_q   <= '0;
      mode_q   <= MODE_AD;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wptr_q   <= wptr_d;
      optr_q   <= optr_d;
      mode_q   <= mode_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Block buffer: word writes while filling; decrypt keeps the recovered
  // plaintext so padding does not depend on ks after EMIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_buf_q[RATE-1 - int'(wptr_q)*PW -: PW] <= bdi_clean;
    end else if (dec_latch) begin
      blk_buf_q <= xr;
    end
  end

  assign bus.bdo_valid   = (state_q == ST_EMIT);
  assign bus.bdo         = bus.bdo_valid ? xr[RATE-1 - int'(optr_q)*PW -: PW] : '0;
  assign bus.blk_valid   = (state_q == ST_BLK);
  assign bus.blk_data    = bus.blk_valid ? pad_blk : '0;
  assign bus.blk_partial = bus.blk_valid && partial;

`ifdef SPOC_TAG_VERIFY_EN
  logic [RATE-1:0] tag_buf;
  assign tag_buf        = blk_buf_q & mask;
  assign bus.auth_valid = (state_q == ST_CMP);
  assign bus.msg_auth   = bus.auth_valid && (tag_buf[RATE-1 -: TAGW] == bus.ks[RATE-1 -: TAGW]);
`else
  assign bus.auth_valid = 1'b0;
  assign bus.msg_auth   = 1'b0;
`endif

endmodule
